uart_rx_ext: RTL and testbench
==============================

Name: uart_rx_ext

Overview:
Serial receiver for the external COM link; the receive-side counterpart of the UART transmitter that drives ext_data_out.
- Samples the asynchronous line ext_data_in using the shared 16x oversampling baud tick.
- Deframes 8N1 characters, LSB first.
- Presents each received byte in a one-entry holding register with a valid/ack handshake to the external-communication bus slave.
- Exports its FSM state for board LED debug.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first)
OVERSAMPLE, 16, baud ticks per bit period (even, >=4)
SYNC_STAGES, 2, synchroniser flops on ext_data_in (>=2)

Ports:
clk  input  1  system clock (divided board clock)
reset  input  1  synchronous, active-high reset
tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
ext_data_in  input  1  asynchronous serial line, idle high
rx_ack  input  1  consumer has taken rx_data; clears rx_valid
rx_data  output  DATA_WIDTH  holding register, last good byte
rx_valid  output  1  holding register full
rx_busy  output  1  frame in progress (state != IDLE)
frame_error  output  1  one-clk pulse when stop bit sampled low
overrun  output  1  sticky; byte overwritten while rx_valid=1
state_rx  output  3  FSM state encoding, for LEDs

Behaviour:
- Reset values:
  - rx_data=0, rx_valid=0, overrun=0, frame_error=0, state_rx=IDLE.
  - Tick counter, bit counter and shift register cleared.
  - Synchroniser flops set to 1.
- Reset mid-frame aborts the frame with no output change other than the reset values above.
- ext_data_in passes through SYNC_STAGES flops; "line" below means the synchronised value.
- Counters advance only on cycles with tick=1. The FSM evaluates sample points on tick cycles only.
- State encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4.
- IDLE:
  - line=0 (any cycle) -> START, tick_cnt=0.
- START:
  - On tick, tick_cnt++.
  - At the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit): line=0 -> DATA, tick_cnt=0, bit_cnt=0. line=1 -> IDLE (glitch rejected, no flags).
- DATA:
  - On tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE-1: shift line in at MSB, shifting right (first bit ends at bit 0); tick_cnt=0; bit_cnt++.
  - After the DATA_WIDTH-th sample -> STOP.
- STOP:
  - Sample at tick_cnt==OVERSAMPLE-1.
  - line=1: load rx_data<=shift, rx_valid<=1, then IDLE.
  - line=0: frame_error pulses 1 clk, holding register untouched, then BREAK.
- BREAK:
  - Stay until line=1, then IDLE. No restart on the low break level.
- Latency: rx_valid and rx_data update on the clk edge after the stop-bit sample tick, which is mid stop bit. The next start edge can be accepted from the following cycle.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid next clk.
  - rx_ack with rx_valid=0 is ignored.
  - rx_data stays stable while rx_valid=1 unless overwritten by a new load.
- Simultaneous load and rx_ack in the same cycle: rx_valid stays 1, rx_data takes the new byte, overrun not set.
- Load while rx_valid=1 and rx_ack=0: rx_data overwritten with the new byte, overrun<=1.
- overrun is cleared by reset or by rx_ack. If set and clear occur in the same cycle, set wins.
- rx_busy = (state != IDLE), combinational from state.
- state_rx = state, registered.

Test Plan:
- Reset: hold reset=1 for 3 clks with ext_data_in=0 -> all outputs 0 except state_rx=0; no frame starts until the line has been seen high then low after reset.
- Good byte: tick every 4 clks, send 0xA5 as start, bits 1,0,1,0,0,1,0,1, stop -> rx_data=0xA5, rx_valid=1 one clk after the stop mid-sample, frame_error=0, overrun=0; rx_ack for 1 clk -> rx_valid=0 next clk.
- Glitch: line low for 5 ticks then high -> FSM returns START->IDLE at tick 8; rx_valid stays 0; then send 0x3C cleanly -> rx_data=0x3C.
- Framing error: send 0x55 with stop bit 0, then hold line low 3 bit times -> frame_error one-clk pulse, state_rx=4 until line rises, rx_valid unchanged (0); next frame 0x0F received correctly.
- Overrun: send 0x11 without ack, then 0x22 -> rx_data=0x22, rx_valid=1, overrun=1; rx_ack -> rx_valid=0, overrun=0.
- Back-to-back with ack at load: send 0xFF then 0x00 with zero idle between frames, asserting rx_ack exactly on the 0x00 load cycle -> rx_data=0x00, rx_valid=1, overrun=0. Then assert reset during DATA of a third frame -> state_rx=0, rx_valid=0.

Source files
------------

// File: rtl/uart_rx_ext_if.sv
// Receive holding-register handshake between uart_rx_ext (master) and the
// external-communication bus slave that consumes bytes.
interface uart_rx_ext_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;

  modport master (output rx_data, output rx_valid, input rx_ack);
  modport slave  (input rx_data, input rx_valid, output rx_ack);
endinterface

// File: rtl/uart_rx_ext.sv
// 8N1 serial receiver for the external COM link: oversampled deframing into a
// one-entry holding register with valid/ack handshake and LED-visible state.
module uart_rx_ext #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          ext_data_in,
  uart_rx_ext_if.master rx,
  output logic          rx_busy,
  output logic          frame_error,
  output logic          overrun,
  output logic [2:0]    state_rx
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [TICK_W-1:0]       tick_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    line;
  logic                    half_pt;
  logic                    full_pt;
  logic                    load;

  assign line     = sync_q[SYNC_STAGES-1];
  assign half_pt  = tick && (tick_cnt == HALF_LAST);
  assign full_pt  = tick && (tick_cnt == FULL_LAST);
  assign load     = (state == STOP) && full_pt && line;
  assign rx_busy  = (state != IDLE);
  assign state_rx = state;

  // Synchroniser, deframing FSM and holding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_data_in};
      frame_error <= 1'b0;

      case (state)
        IDLE: begin
          if (!line) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (half_pt) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= line ? IDLE : DATA;
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        DATA: begin
          if (full_pt) begin
            shift    <= {line, shift[DATA_WIDTH-1:1]};
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        STOP: begin
          if (full_pt) begin
            tick_cnt <= '0;
            if (line) begin
              state <= IDLE;
            end else begin
              frame_error <= 1'b1;
              state       <= BREAK;
            end
          end else if (tick) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
        BREAK: begin
          // Wait out the low level; a new start needs a fresh falling edge.
          if (line) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A load in the ack cycle keeps valid set: the new byte is still unread.
      if (load) begin
        rx.rx_data  <= shift;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_ack && rx.rx_valid) begin
        rx.rx_valid <= 1'b0;
      end

      if (load && rx.rx_valid && !rx.rx_ack) begin
        overrun <= 1'b1;
      end else if (rx.rx_ack) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed and randomized frame-level checks of uart_rx_ext against a
// byte/flag reference model.
module tb_uart_rx_ext;

  localparam int unsigned DW       = 8;
  localparam int unsigned OS       = 16;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned BIT_CLKS = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick = 1'b0;
  logic       ext_data_in;
  logic       rx_busy;
  logic       frame_error;
  logic       overrun;
  logic [2:0] state_rx;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int div       = 0;
  int fe_cycles = 0;
  int rise_cyc  = -1;
  logic valid_d = 1'b0;

  uart_rx_ext_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_ext #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .ext_data_in(ext_data_in),
    .rx         (bus),
    .rx_busy    (rx_busy),
    .frame_error(frame_error),
    .overrun    (overrun),
    .state_rx   (state_rx)
  );

  always #5 clk = ~clk;

  // Baud tick every TICK_DIV clocks.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    div  <= (div == int'(TICK_DIV) - 1) ? 0 : div + 1;
    tick <= (div == int'(TICK_DIV) - 1);
  end

  always @(negedge clk) begin
    if (frame_error === 1'b1) fe_cycles++;
    if (bus.rx_valid === 1'b1 && valid_d !== 1'b1) rise_cyc = cyc;
    valid_d = bus.rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    ext_data_in = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic idle(input int n);
    ext_data_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  int         m_fe;

  initial begin
    int t0;
    int lat;
    bit done;
    int entries;
    int nt;
    logic [2:0] prev_st;

    reset       = 1'b1;
    ext_data_in = 1'b0;
    bus.rx_ack  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(bus.rx_data), 32'h0);
    check("rst_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_busy",  32'(rx_busy), 32'h0);
    check("rst_fe",    32'(frame_error), 32'h0);
    check("rst_ovr",   32'(overrun), 32'h0);
    check("rst_state", 32'(state_rx), 32'h0);
    ext_data_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle(BIT_CLKS);
    check("post_rst_idle", 32'(state_rx), 32'h0);

    // Good byte with latency window: mid stop bit is 9.5 bit times after the edge.
    rise_cyc = -1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    lat = rise_cyc - t0;
    check("a5_data",  32'(bus.rx_data), 32'hA5);
    check("a5_valid", 32'(bus.rx_valid), 32'h1);
    check("a5_fe",    32'(fe_cycles), 32'h0);
    check("a5_ovr",   32'(overrun), 32'h0);
    check("a5_latency_window", 32'(lat >= 600 && lat <= 620), 32'h1);
    check("a5_idle",  32'(rx_busy), 32'h0);
    ack_pulse();
    check("a5_ack_clears", 32'(bus.rx_valid), 32'h0);
    ack_pulse();
    check("ack_no_valid_ignored", 32'(bus.rx_valid), 32'h0);
    check("ack_no_valid_data",    32'(bus.rx_data), 32'hA5);

    // Glitch: 5 ticks low is rejected at the mid-start sample.
    ext_data_in = 1'b0;
    repeat (20) @(negedge clk);
    ext_data_in = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch_in_start", 32'(state_rx), 32'h1);
    repeat (24) @(negedge clk);
    check("glitch_rejected", 32'(state_rx), 32'h0);
    check("glitch_valid",    32'(bus.rx_valid), 32'h0);
    check("glitch_fe",       32'(fe_cycles), 32'h0);
    idle(BIT_CLKS);
    send_frame(8'h3C, 1'b1);
    check("3c_data",  32'(bus.rx_data), 32'h3C);
    check("3c_valid", 32'(bus.rx_valid), 32'h1);
    ack_pulse();

    // Framing error followed by a break level.
    send_frame(8'h55, 1'b0);
    send_bit(1'b0);
    check("break_state", 32'(state_rx), 32'h4);
    send_bit(1'b0);
    send_bit(1'b0);
    check("fe_one_pulse",   32'(fe_cycles), 32'h1);
    check("fe_valid",       32'(bus.rx_valid), 32'h0);
    check("fe_data_kept",   32'(bus.rx_data), 32'h3C);
    check("break_held",     32'(state_rx), 32'h4);
    idle(BIT_CLKS);
    check("break_released", 32'(state_rx), 32'h0);
    send_frame(8'h0F, 1'b1);
    check("0f_data",  32'(bus.rx_data), 32'h0F);
    check("0f_valid", 32'(bus.rx_valid), 32'h1);
    check("0f_fe",    32'(fe_cycles), 32'h1);
    ack_pulse();

    // Overrun.
    send_frame(8'h11, 1'b1);
    idle(BIT_CLKS);
    check("ovr_first_clean", 32'(overrun), 32'h0);
    send_frame(8'h22, 1'b1);
    check("ovr_data",  32'(bus.rx_data), 32'h22);
    check("ovr_valid", 32'(bus.rx_valid), 32'h1);
    check("ovr_flag",  32'(overrun), 32'h1);
    ack_pulse();
    check("ovr_ack_valid", 32'(bus.rx_valid), 32'h0);
    check("ovr_ack_flag",  32'(overrun), 32'h0);

    // Back-to-back frames, ack coincident with the second load.
    done    = 1'b0;
    entries = 0;
    nt      = 0;
    prev_st = state_rx;
    fork
      begin
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
      end
      begin
        for (int c = 0; c < 3000 && !done; c++) begin
          @(negedge clk);
          if (state_rx == 3'd3 && prev_st != 3'd3) entries++;
          prev_st = state_rx;
          if (entries == 2 && state_rx == 3'd3 && tick) begin
            nt++;
            if (nt == OS) begin
              bus.rx_ack = 1'b1;
              @(negedge clk);
              bus.rx_ack = 1'b0;
              done = 1'b1;
            end
          end
        end
      end
    join
    check("b2b_ack_synced", 32'(done), 32'h1);
    check("b2b_data",  32'(bus.rx_data), 32'h00);
    check("b2b_valid", 32'(bus.rx_valid), 32'h1);
    check("b2b_ovr",   32'(overrun), 32'h0);

    // Reset in the middle of a data phase.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_frame_busy", 32'(state_rx), 32'h2);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_state", 32'(state_rx), 32'h0);
    check("midrst_valid", 32'(bus.rx_valid), 32'h0);
    check("midrst_data",  32'(bus.rx_data), 32'h0);
    check("midrst_busy",  32'(rx_busy), 32'h0);
    ext_data_in = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    idle(BIT_CLKS);

    // Randomized frames against a frame-level model.
    m_data    = 8'h00;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    m_fe      = 0;
    fe_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      bit bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
      end
      send_frame(b, !bad);
      if (bad) begin
        send_bit(1'b0);
        m_fe++;
      end else begin
        if (m_valid) m_ovr = 1'b1;
        m_data  = b;
        m_valid = 1'b1;
      end
      idle($urandom_range(1, 40));
      check($sformatf("rnd%0d_data", k),  32'(bus.rx_data), 32'(m_data));
      check($sformatf("rnd%0d_valid", k), 32'(bus.rx_valid), 32'(m_valid));
      check($sformatf("rnd%0d_ovr", k),   32'(overrun), 32'(m_ovr));
      check($sformatf("rnd%0d_fe", k),    32'(fe_cycles), 32'(m_fe));
      check($sformatf("rnd%0d_idle", k),  32'(state_rx), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
